mdu_sequencer: RTL and testbench

- Iterative multiply/divide unit for the RV32M subset: MUL, MULHU, DIVU, REMU.
- Sits beside the single-cycle ALU as a multi-cycle resource. The control unit issues `start_i` and stalls the PC while `busy_o` is high, then writes `result_o` to the register file on `done_o`.
- One bit is retired per cycle: shift-add for multiply, restoring subtract-shift for divide.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_sequencer_if.sv | 26 ++
 rtl/mdu_iter_step.sv | 52 +++++
 rtl/mdu_sequencer.sv | 124 ++++++++++++
 tb/tb_mdu_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the iterative multiply/divide unit.
//   mdu_op_e    - operation encodings (MUL, MULHU, DIVU, REMU)
//   mdu_state_e - sequencer states (IDLE, RUN, DONE)
//   op_is_div   - true for the two divide-class operations
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'b00,
        MDU_MULHU = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_REMU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIVU) || (op == MDU_REMU);
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: request/response bundle between the control unit and the MDU.
//   start_i, op_i, A_i, B_i    - request (driven by the master / control unit)
//   busy_o, done_o, result_o   - status and result (driven by the slave / MDU)
interface mdu_sequencer_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start_i;
    mdu_op_e          op_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, A_i, B_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, A_i, B_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one combinational iteration of the MDU datapath.
//   is_div_i   - 1: restoring divide step, 0: shift-add multiply step
//   hi_i/lo_i  - working pair: {product_hi, product_lo/multiplier} or {rem, quot}
//   opnd_a_i   - multiplicand (multiply only)
//   opnd_b_i   - divisor (divide only)
//   hi_o/lo_o  - working pair after this iteration
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_a_i,
    input  logic [WIDTH-1:0] opnd_b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic             no_borrow_s;
    logic [WIDTH-1:0] diff_s;

    // Single-iteration next-value computation for both operation classes
    always_comb begin
        // Multiply: the low half doubles as the multiplier, so its LSB selects the add
        // and the carry of the add becomes the product MSB after the right shift.
        sum_s = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_a_i} : {(WIDTH+1){1'b0}});
        // Divide: the remainder keeps the bit shifted out of its top, because
        // 2*rem+1 can exceed WIDTH bits when the divisor is close to 2^WIDTH.
        rem_sh_s    = {hi_i, lo_i[WIDTH-1]};
        no_borrow_s = (rem_sh_s >= {1'b0, opnd_b_i});
        // When no borrow occurs the true difference is below the divisor, so the
        // low WIDTH bits of a modular subtract are exact.
        diff_s      = rem_sh_s[WIDTH-1:0] - opnd_b_i;
        if (is_div_i) begin
            if (no_borrow_s) begin
                hi_o = diff_s;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rem_sh_s[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_o = sum_s[WIDTH:1];
            lo_o = {sum_s[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M MUL/MULHU/DIVU/REMU unit, one bit per cycle.
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset; aborts any operation silently
//   bus    - mdu_sequencer_if slave: start_i/op_i/A_i/B_i in, busy_o/done_o/result_o out
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    mdu_sequencer_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e       state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_is_div(op_q)),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_a_i (a_q),
        .opnd_b_i (b_q),
        .hi_o     (step_hi_s),
        .lo_o     (step_lo_s)
    );

    // State, operand, working and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= MDU_MUL;
            cnt_q    <= {CNT_W{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // Next-state, operand capture, iteration and result selection
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    op_d  = bus.op_i;
                    a_d   = bus.A_i;
                    b_d   = bus.B_i;
                    hi_d  = {WIDTH{1'b0}};
                    cnt_d = {CNT_W{1'b0}};
                    if (op_is_div(bus.op_i)) begin
                        // Low half starts as the dividend and fills with quotient bits.
                        lo_d = bus.A_i;
                        if (bus.B_i == {WIDTH{1'b0}}) begin
                            state_d  = DONE;
                            result_d = (bus.op_i == MDU_DIVU) ? {WIDTH{1'b1}} : bus.A_i;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        // Low half starts as the multiplier and fills with product bits.
                        lo_d    = bus.B_i;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                hi_d  = step_hi_s;
                lo_d  = step_lo_s;
                cnt_d = cnt_q + CNT_W'(32'd1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    case (op_q)
                        MDU_MUL, MDU_DIVU:   result_d = step_lo_s;
                        MDU_MULHU, MDU_REMU: result_d = step_hi_s;
                        default:             result_d = result_q;
                    endcase
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.done_o   = (state_q == DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int TIMEOUT = 100;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mdu_sequencer_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic with RISC-V divide-by-zero rules.
    function automatic logic [31:0] ref_model(input mdu_op_e op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            MDU_MUL:   return p[31:0];
            MDU_MULHU: return p[63:32];
            MDU_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            MDU_REMU:  return (b == 32'd0) ? a : a % b;
            default:   return 32'h0;
        endcase
    endfunction

    // Called at a negedge with the DUT idle. Returns at the negedge after done.
    task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        logic [31:0] exp;
        int          exp_lat;
        int          cyc;
        int          busy_cnt;
        exp     = ref_model(op, a, b);
        exp_lat = ((op == MDU_DIVU || op == MDU_REMU) && b == 32'd0) ? 1 : 33;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.A_i     = a;
        bus.B_i     = b;
        @(negedge clk);
        cyc      = 1;
        busy_cnt = 0;
        bus.start_i = 1'b0;
        while (bus.done_o !== 1'b1 && cyc < TIMEOUT) begin
            if (bus.busy_o === 1'b1) busy_cnt++;
            // Operand churn and an optional stray start must have no effect.
            bus.start_i = inject && (cyc == 10);
            bus.op_i    = MDU_DIVU;
            bus.A_i     = $urandom();
            bus.B_i     = $urandom_range(0, 3);
            @(negedge clk);
            cyc++;
        end
        bus.start_i = 1'b0;
        if (bus.busy_o === 1'b1) busy_cnt++;
        check_val({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check_val({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check_val({tag, " result"}, bus.result_o, exp);
        @(negedge clk);
        check_val({tag, " done_pulse"}, {31'd0, bus.done_o}, 32'd0);
        check_val({tag, " idle"}, {31'd0, bus.busy_o}, 32'd0);
        check_val({tag, " held"}, bus.result_o, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        mdu_op_e     rop;
        bit          seen;
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = MDU_MUL;
        bus.A_i     = 32'd0;
        bus.B_i     = 32'd0;
        repeat (2) @(negedge clk);
        check_val("reset busy", {31'd0, bus.busy_o}, 32'd0);
        check_val("reset done", {31'd0, bus.done_o}, 32'd0);
        check_val("reset result", bus.result_o, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mul7x6", MDU_MUL, 32'd7, 32'd6, 1'b0);
        run_op("mul_ff", MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu_ff", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("divu100_7", MDU_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("remu100_7", MDU_REMU, 32'd100, 32'd7, 1'b0);
        run_op("divu5_9", MDU_DIVU, 32'd5, 32'd9, 1'b0);
        run_op("remu5_9", MDU_REMU, 32'd5, 32'd9, 1'b0);
        run_op("divu_by0", MDU_DIVU, 32'h0000_1234, 32'd0, 1'b0);
        run_op("remu_by0", MDU_REMU, 32'd123, 32'd0, 1'b0);
        run_op("mul3x5_ign", MDU_MUL, 32'd3, 32'd5, 1'b1);
        run_op("b2b_divu", MDU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("remu_bigdiv", MDU_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);

        // Abort a divide mid-operation with an asynchronous reset.
        bus.start_i = 1'b1;
        bus.op_i    = MDU_DIVU;
        bus.A_i     = 32'd1000;
        bus.B_i     = 32'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        check_val("abort busy_before", {31'd0, bus.busy_o}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("abort busy", {31'd0, bus.busy_o}, 32'd0);
        check_val("abort done", {31'd0, bus.done_o}, 32'd0);
        check_val("abort result", bus.result_o, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) seen = 1'b1;
        end
        check_val("abort no_done", {31'd0, seen}, 32'd0);
        run_op("remu1000_3", MDU_REMU, 32'd1000, 32'd3, 1'b0);

        // Randomized operations, including zero divisors and extreme operands.
        for (int i = 0; i < 40; i++) begin
            rop = mdu_op_e'(2'($urandom_range(0, 3)));
            ra  = $urandom();
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 16));
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom();
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
            run_op($sformatf("rand%0d", i), rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
